hazard_scoreboard: RTL and testbench

Parametrised forwarding and interlock unit for the integer pipeline, sitting at the decode→execute boundary. It tracks the destination register, producer class and result-ready countdown of every in-flight instruction across `NUM_STAGES` downstream pipeline slots. It produces per-operand forward selects and a load-use stall. It extends the fixed three-stage forwarding scheme to arbitrary pipeline depth and multi-cycle load latency, and adds flush handling.

---
 rtl/hazard_scoreboard_if.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/scoreboard handshake bundle; HAZARD_PERF_EN adds perf counter outputs.
interface hazard_scoreboard_if #(
    parameter int NUM_STAGES = 2
);
    localparam int FSW = $clog2(NUM_STAGES + 1);

    logic           issue_valid;
    logic           issue_we;
    logic [4:0]     issue_rd;
    logic [1:0]     issue_kind;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic           rs1_used;
    logic           rs2_used;
    logic           flush;
    logic [FSW-1:0] fwd_sel_1;
    logic [FSW-1:0] fwd_sel_2;
    logic           stall;
`ifdef HAZARD_PERF_EN
    logic [31:0]    stall_cycles;
    logic [31:0]    fwd_events;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_kind,
        output rs1, rs2, rs1_used, rs2_used, flush,
        input  fwd_sel_1, fwd_sel_2, stall, stall_cycles, fwd_events
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_kind,
        input  rs1, rs2, rs1_used, rs2_used, flush,
        output fwd_sel_1, fwd_sel_2, stall, stall_cycles, fwd_events
    );
`else
    modport master (
        output issue_valid, issue_we, issue_rd, issue_kind,
        output rs1, rs2, rs1_used, rs2_used, flush,
        input  fwd_sel_1, fwd_sel_2, stall
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_kind,
        input  rs1, rs2, rs1_used, rs2_used, flush,
        output fwd_sel_1, fwd_sel_2, stall
    );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding select and load-use interlock over NUM_STAGES in-flight slots.
// Optional stall/forward performance counters enabled by HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int NUM_STAGES   = 2,
    parameter int LOAD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave bus
);
    localparam int         FSW       = $clog2(NUM_STAGES + 1);
    localparam logic [1:0] KIND_LOAD = 2'd1;
    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LATENCY - 1);

    logic [NUM_STAGES-1:0]      v_q, v_d;
    logic [NUM_STAGES-1:0][4:0] rd_q, rd_d;
    logic [NUM_STAGES-1:0][1:0] kind_q, kind_d;
    logic [NUM_STAGES-1:0][2:0] cnt_q, cnt_d;

    logic [FSW-1:0] sel1, sel2;
    logic           haz1, haz2;
    logic           stall;
    logic           insert;

    // Scan oldest to youngest so the youngest match overwrites and shadows older ones.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (bus.issue_valid && bus.rs1_used && bus.rs1 != 5'd0 &&
                v_q[i] && rd_q[i] == bus.rs1) begin
                haz1 = (cnt_q[i] != 3'd0) && (kind_q[i] == KIND_LOAD);
                sel1 = haz1 ? '0 : FSW'(i + 1);
            end
            if (bus.issue_valid && bus.rs2_used && bus.rs2 != 5'd0 &&
                v_q[i] && rd_q[i] == bus.rs2) begin
                haz2 = (cnt_q[i] != 3'd0) && (kind_q[i] == KIND_LOAD);
                sel2 = haz2 ? '0 : FSW'(i + 1);
            end
        end
    end

    assign stall  = (haz1 || haz2) && !bus.flush;
    assign insert = bus.issue_valid && bus.issue_we && bus.issue_rd != 5'd0 &&
                    !stall && !bus.flush;

    assign bus.fwd_sel_1 = sel1;
    assign bus.fwd_sel_2 = sel2;
    assign bus.stall     = stall;

    // Downstream pipeline never stalls: every slot shifts each cycle, the last one retires.
    always_comb begin
        v_d       = '0;
        rd_d      = '0;
        kind_d    = '0;
        cnt_d     = '0;
        v_d[0]    = insert;
        rd_d[0]   = bus.issue_rd;
        kind_d[0] = bus.issue_kind;
        cnt_d[0]  = (bus.issue_kind == KIND_LOAD) ? LOAD_CNT : 3'd0;
        for (int i = 1; i < NUM_STAGES; i++) begin
            v_d[i]    = v_q[i-1];
            rd_d[i]   = rd_q[i-1];
            kind_d[i] = kind_q[i-1];
            cnt_d[i]  = (cnt_q[i-1] != 3'd0) ? cnt_q[i-1] - 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            rd_q   <= '0;
            kind_q <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            rd_q   <= rd_d;
            kind_q <= kind_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_events_q, fwd_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_events_d   = fwd_events_q;
        if (stall) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else if (sel1 != '0 || sel2 != '0) begin
            fwd_events_d = fwd_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.fwd_events   = fwd_events_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed checks of hazard_scoreboard with NUM_STAGES=2, LOAD_LATENCY=2.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    hazard_scoreboard_if #(.NUM_STAGES(2)) bus ();

    hazard_scoreboard #(
        .NUM_STAGES   (2),
        .LOAD_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] kind, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic fl);
        bus.issue_valid = v;
        bus.issue_we    = we;
        bus.issue_rd    = rd;
        bus.issue_kind  = kind;
        bus.rs1         = r1;
        bus.rs1_used    = u1;
        bus.rs2         = r2;
        bus.rs2_used    = u2;
        bus.flush       = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check("reset_fwd1", int'(bus.fwd_sel_1), 0);
        check("reset_fwd2", int'(bus.fwd_sel_2), 0);
        check("reset_stall", int'(bus.stall), 0);
`ifdef HAZARD_PERF_EN
        check("reset_stall_cycles", int'(bus.stall_cycles), 0);
        check("reset_fwd_events", int'(bus.fwd_events), 0);
`endif
        rst = 1'b0;
        tick();

        // ALU back-to-back
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 5, 1, 0, 0, 0);
        check("alu_fwd1_slot0", int'(bus.fwd_sel_1), 1);
        check("alu_nostall", int'(bus.stall), 0);
        tick();
        check("alu_fwd1_slot1", int'(bus.fwd_sel_1), 2);
        idle(2);

        // Load-use: one stall cycle, then forward from slot 1
        drive(1, 1, 7, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 8, 0, 0, 0, 7, 1, 0);
        check("lu_stall", int'(bus.stall), 1);
        tick();
        check("lu_stall_released", int'(bus.stall), 0);
        check("lu_fwd2", int'(bus.fwd_sel_2), 2);
        tick();
        drive(1, 0, 0, 0, 8, 1, 0, 0, 0);
        check("lu_held_insn_inserted", int'(bus.fwd_sel_1), 1);
        idle(2);

        // x0 destination never tracked
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0);
        check("x0_fwd1", int'(bus.fwd_sel_1), 0);
        check("x0_fwd2", int'(bus.fwd_sel_2), 0);
        idle(2);

        // Unused rs2 operand ignored
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 9, 0, 0);
        check("unused_rs2", int'(bus.fwd_sel_2), 0);
        drive(1, 0, 0, 0, 1, 1, 9, 1, 0);
        check("used_rs2", int'(bus.fwd_sel_2), 1);
        idle(2);

        // Shadowing: younger load hides older add
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 3, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 3, 1, 0, 0, 0);
        check("shadow_stall", int'(bus.stall), 1);
        tick();
        check("shadow_nostall", int'(bus.stall), 0);
        check("shadow_fwd1", int'(bus.fwd_sel_1), 2);
        idle(2);

        // Flush wins over hazard and inserts a bubble
        drive(1, 1, 7, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 10, 0, 0, 0, 7, 1, 1);
        check("flush_stall", int'(bus.stall), 0);
        tick();
        drive(1, 0, 0, 0, 10, 1, 0, 0, 0);
        check("flush_no_false_match", int'(bus.fwd_sel_1), 0);
        check("flush_next_nostall", int'(bus.stall), 0);
        idle(2);

        // Asynchronous reset with both slots valid
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 6, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 6, 1, 4, 1, 0);
        check("pre_reset_fwd1", int'(bus.fwd_sel_1), 1);
        check("pre_reset_fwd2", int'(bus.fwd_sel_2), 2);
        rst = 1'b1;
        #1;
        check("async_reset_fwd1", int'(bus.fwd_sel_1), 0);
        check("async_reset_fwd2", int'(bus.fwd_sel_2), 0);
        check("async_reset_stall", int'(bus.stall), 0);
        #1;
        rst = 1'b0;
        idle(1);

`ifdef HAZARD_PERF_EN
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 7, 1, 0, 0, 0, 0, 0);
            tick();
            drive(1, 0, 0, 0, 0, 0, 7, 1, 0);
            tick();
            tick();
            idle(2);
        end
        check("perf_stall_cycles", int'(bus.stall_cycles), 3);
        check("perf_fwd_events", int'(bus.fwd_events), 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
